// File: rtl/s3g_pkg.sv
// Shared definitions for the s3g transmit path: arbiter state encoding, owner
// encoding, payload sizing and the length clamp helper.
package s3g_pkg;

  localparam int S3G_MAX_PAYLOAD = 16;
  localparam int S3G_BUF_W       = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Oversized requests are trimmed to the transmitter buffer depth; zero passes through.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input int unsigned max_len);
    logic [7:0] lim;
    lim = max_len[7:0];
    return (len > lim) ? lim : len;
  endfunction

endpackage

// File: rtl/s3g_tx_arbiter_if.sv
// Requester and transmitter signals of the s3g_tx arbiter. The master modport is
// the arbiter; the slave modport is the requesters plus s3g_tx.
interface s3g_tx_arbiter_if;

  logic                           a_req;
  logic [7:0]                     a_payload_len;
  logic [s3g_pkg::S3G_BUF_W-1:0]  a_buf;
  logic                           a_ack;

  logic                           b_req;
  logic [7:0]                     b_payload_len;
  logic [s3g_pkg::S3G_BUF_W-1:0]  b_buf;
  logic                           b_ack;

  logic                           tx_busy;
  logic                           tx_packet_wr;
  logic [7:0]                     tx_payload_len;
  logic [s3g_pkg::S3G_BUF_W-1:0]  tx_buf;
  logic                           tx_owner;
  logic                           tx_timeout;

  modport master (
    input  a_req, a_payload_len, a_buf,
    input  b_req, b_payload_len, b_buf,
    input  tx_busy,
    output a_ack, b_ack,
    output tx_packet_wr, tx_payload_len, tx_buf, tx_owner, tx_timeout
  );

  modport slave (
    output a_req, a_payload_len, a_buf,
    output b_req, b_payload_len, b_buf,
    output tx_busy,
    input  a_ack, b_ack,
    input  tx_packet_wr, tx_payload_len, tx_buf, tx_owner, tx_timeout
  );

endinterface

// File: rtl/s3g_tx_arbiter.sv
// Two-way round-robin arbiter sharing s3g_tx between command replies (A) and status
// reports (B). Define S3G_TX_ARB_TIMEOUT_EN to abandon packets whose busy never rises.
module s3g_tx_arbiter
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD  = S3G_MAX_PAYLOAD
`ifdef S3G_TX_ARB_TIMEOUT_EN
 ,parameter int BUSY_TIMEOUT = 15
`endif
) (
  input logic               clk,
  input logic               rst,
  s3g_tx_arbiter_if.master  bus
);

  arb_state_t state;
  owner_t     last_grant;
  logic       take_b;

`ifdef S3G_TX_ARB_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);
  logic [CNT_W-1:0] busy_cnt;
`endif

  // B wins when it is alone, or when both ask and A was served last.
  assign take_b = bus.b_req && (!bus.a_req || (last_grant == OWNER_A));

  // NOTE: every register here uses <= so all next-state values come from the same
  // pre-edge snapshot; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the payload registers are reset too, because they are visible outputs
      // that must read 0 after reset, not just internal storage.
      state              <= ST_IDLE;
      last_grant         <= OWNER_B;
      bus.a_ack          <= 1'b0;
      bus.b_ack          <= 1'b0;
      bus.tx_packet_wr   <= 1'b0;
      bus.tx_payload_len <= '0;
      bus.tx_buf         <= '0;
      bus.tx_owner       <= 1'b0;
      bus.tx_timeout     <= 1'b0;
`ifdef S3G_TX_ARB_TIMEOUT_EN
      busy_cnt           <= '0;
`endif
    end else begin
      bus.a_ack        <= 1'b0;
      bus.b_ack        <= 1'b0;
      bus.tx_packet_wr <= 1'b0;
      bus.tx_timeout   <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!bus.tx_busy && (bus.a_req || bus.b_req)) begin
            if (take_b) begin
              bus.tx_payload_len <= clamp_len(bus.b_payload_len, MAX_PAYLOAD);
              bus.tx_buf         <= bus.b_buf;
              bus.tx_owner       <= OWNER_B;
              bus.b_ack          <= 1'b1;
              last_grant         <= OWNER_B;
            end else begin
              bus.tx_payload_len <= clamp_len(bus.a_payload_len, MAX_PAYLOAD);
              bus.tx_buf         <= bus.a_buf;
              bus.tx_owner       <= OWNER_A;
              bus.a_ack          <= 1'b1;
              last_grant         <= OWNER_A;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          bus.tx_packet_wr <= 1'b1;
          state            <= ST_WAIT_BUSY;
`ifdef S3G_TX_ARB_TIMEOUT_EN
          busy_cnt         <= '0;
`endif
        end

        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= ST_WAIT_IDLE;
`ifdef S3G_TX_ARB_TIMEOUT_EN
          end else if (busy_cnt == CNT_MAX) begin
            // Transmitter never accepted the packet; drop it rather than retry.
            bus.tx_timeout <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
`endif
          end
        end

        ST_WAIT_IDLE: begin
          if (!bus.tx_busy) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Directed bench for s3g_tx_arbiter: grants, round-robin, clamping, reset and the
// busy-wait behaviour of whichever build is compiled.
module tb_s3g_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  s3g_tx_arbiter_if bus ();

  s3g_tx_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it, where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".acks"}, {bus.a_ack, bus.b_ack}, 2'b00);
    check({tag, ".wr"},   bus.tx_packet_wr, 1'b0);
    check({tag, ".len"},  bus.tx_payload_len, 8'd0);
    check({tag, ".buf"},  bus.tx_buf, 128'd0);
    check({tag, ".own"},  bus.tx_owner, 1'b0);
    check({tag, ".tmo"},  bus.tx_timeout, 1'b0);
  endtask

  // Called right after the packet_wr cycle: model s3g_tx busy for two cycles, return to IDLE.
  task automatic finish_packet(input string tag);
    bus.tx_busy = 1'b1;
    tick();
    check({tag, ".busy_noack"}, {bus.a_ack, bus.b_ack, bus.tx_packet_wr}, 3'b000);
    tick();
    bus.tx_busy = 1'b0;
    tick();
  endtask

  // From IDLE with busy low: expect a grant on the next edge, then packet_wr one edge later.
  task automatic do_grant(input string tag, input logic owner, input logic [7:0] len,
                          input logic [127:0] buf_exp, input logic keep_req);
    tick();
    check({tag, ".ack"}, {bus.a_ack, bus.b_ack}, owner ? 2'b01 : 2'b10);
    check({tag, ".wr0"}, bus.tx_packet_wr, 1'b0);
    check({tag, ".len"}, bus.tx_payload_len, len);
    check({tag, ".buf"}, bus.tx_buf, buf_exp);
    check({tag, ".own"}, bus.tx_owner, owner);
    if (!keep_req) begin
      if (owner) bus.b_req = 1'b0;
      else       bus.a_req = 1'b0;
    end
    tick();
    check({tag, ".wr1"}, bus.tx_packet_wr, 1'b1);
    check({tag, ".ack0"}, {bus.a_ack, bus.b_ack}, 2'b00);
    finish_packet(tag);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] len_in  [5] = '{8'd0, 8'd16, 8'd17, 8'd20, 8'd255};
  logic [7:0] len_exp [5] = '{8'd0, 8'd16, 8'd16, 8'd16, 8'd16};

  initial begin
    logic [127:0] pa, pb;
    pa = 128'h0302_01;
    pb = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    bus.a_req = 1'b0; bus.a_payload_len = '0; bus.a_buf = '0;
    bus.b_req = 1'b0; bus.b_payload_len = '0; bus.b_buf = '0;
    bus.tx_busy = 1'b0;

    apply_reset();
    check_idle_outputs("reset");

    // 1: A alone, len 3, bytes 01 02 03
    bus.a_req = 1'b1; bus.a_payload_len = 8'd3; bus.a_buf = pa;
    do_grant("t1", 1'b0, 8'd3, 128'h030201, 1'b0);
    tick();
    check("t1.quiet", {bus.a_ack, bus.b_ack, bus.tx_packet_wr}, 3'b000);
    check("t1.hold_len", bus.tx_payload_len, 8'd3);

    // 2: both from reset, A first then B
    apply_reset();
    bus.a_req = 1'b1; bus.a_payload_len = 8'd2; bus.a_buf = 128'hAABB;
    bus.b_req = 1'b1; bus.b_payload_len = 8'd16; bus.b_buf = pb;
    do_grant("t2a", 1'b0, 8'd2, 128'hAABB, 1'b0);
    do_grant("t2b", 1'b1, 8'd16, pb, 1'b0);

    // 3: A keeps requesting while B waits -> A, B, A
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    do_grant("t3a0", 1'b0, 8'd2, 128'hAABB, 1'b1);
    do_grant("t3b",  1'b1, 8'd16, pb, 1'b0);
    do_grant("t3a1", 1'b0, 8'd2, 128'hAABB, 1'b0);

    // 4: length clamp table on B, and one oversized A
    for (int i = 0; i < 5; i++) begin
      bus.b_req = 1'b1; bus.b_payload_len = len_in[i];
      do_grant($sformatf("t4b%0d", i), 1'b1, len_exp[i], pb, 1'b0);
    end
    bus.a_req = 1'b1; bus.a_payload_len = 8'd20;
    do_grant("t4a", 1'b0, 8'd16, 128'hAABB, 1'b0);

    // Busy held in IDLE blocks grants
    bus.tx_busy = 1'b1; bus.a_req = 1'b1; bus.a_payload_len = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("busyhold%0d", i), {bus.a_ack, bus.b_ack}, 2'b00);
    end
    bus.tx_busy = 1'b0;
    do_grant("busyrel", 1'b0, 8'd5, 128'hAABB, 1'b0);

    // 5: reset in WAIT_IDLE abandons the packet (last grant was A before reset)
    bus.a_req = 1'b1; bus.a_payload_len = 8'd7;
    tick();
    check("t5.ack", bus.a_ack, 1'b1);
    bus.a_req = 1'b0;
    tick();
    bus.tx_busy = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("t5.rst");
    rst = 1'b1;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5.nowr%0d", i), {bus.tx_packet_wr, bus.a_ack, bus.b_ack}, 3'b000);
    end
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    bus.b_payload_len = 8'd9;
    do_grant("t5a", 1'b0, 8'd7, 128'hAABB, 1'b0);
    do_grant("t5b", 1'b1, 8'd9, pb, 1'b0);

    // 6: busy never rises after packet_wr, with B pending
    bus.a_req = 1'b1; bus.a_payload_len = 8'd1;
    tick();
    check("t6.ack", bus.a_ack, 1'b1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_payload_len = 8'd4;
    tick();
    check("t6.wr", bus.tx_packet_wr, 1'b1);
`ifdef S3G_TX_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("t6.wait%0d", i), {bus.tx_timeout, bus.b_ack}, 2'b00);
    end
    tick();
    check("t6.tmo", bus.tx_timeout, 1'b1);
    do_grant("t6b", 1'b1, 8'd4, pb, 1'b0);
    check("t6.tmo_once", bus.tx_timeout, 1'b0);
`else
    for (int i = 1; i < 25; i++) begin
      tick();
      check($sformatf("t6.wait%0d", i), {bus.tx_timeout, bus.b_ack, bus.a_ack}, 3'b000);
    end
    finish_packet("t6.late");
    do_grant("t6b", 1'b1, 8'd4, pb, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
